// File: rtl/butterfly_pkg.sv
// Shared types and constants for the 4x4 butterfly switch datapath.
package butterfly_pkg;

  // Phit type field encoding (top two bits of every phit).
  typedef enum logic [1:0] {
    PT_IDLE    = 2'd0,
    PT_RSVD    = 2'd1,
    PT_PAYLOAD = 2'd2,
    PT_HEAD    = 2'd3
  } phit_type_e;

  localparam logic [1:0] HEAD    = 2'd3;
  localparam logic [1:0] PAYLOAD = 2'd2;

  // Each switch stage consumes one route field of this width.
  localparam int ROUTE_W   = 2;
  localparam int NUM_PORTS = 4;

  // Output port framing state.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_e;

endpackage

// File: rtl/route_shifter.sv
// Combinational head rewrite: keep the type, drop the consumed route
// field by shifting the remaining route bits up, zero-fill the bottom.
module route_shifter
  import butterfly_pkg::*;
#(
  parameter int PHIT_W = 8
) (
  input  logic [PHIT_W-1:0] phit_in,
  output logic [PHIT_W-1:0] phit_out
);

  // Bits [PHIT_W-3:PHIT_W-4] are the field this stage used; discard them.
  assign phit_out = {phit_in[PHIT_W-1 -: 2], phit_in[PHIT_W-5:0], {ROUTE_W{1'b0}}};

endmodule

// File: rtl/output_port_stage.sv
// Per-output-port stage: one-hot input mux, head route strip, packet
// framing FSM, saturating traffic counters and sticky error flags.
module output_port_stage
  import butterfly_pkg::*;
#(
  parameter int PHIT_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [PHIT_W-1:0] i_phit0,
  input  logic [PHIT_W-1:0] i_phit1,
  input  logic [PHIT_W-1:0] i_phit2,
  input  logic [PHIT_W-1:0] i_phit3,
  input  logic [3:0]        i_select,
  input  logic              i_shift,
  input  logic              i_clr_stats,
  input  logic              i_clr_err,
  output logic [PHIT_W-1:0] o_phit,
  output logic              o_valid,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_pkt_cnt,
  output logic [CNT_W-1:0]  o_phit_cnt,
  output logic [2:0]        o_err
);

  logic [PHIT_W-1:0] phits [NUM_PORTS];
  logic [PHIT_W-1:0] sel_phit;
  logic [PHIT_W-1:0] shifted_phit;
  logic [PHIT_W-1:0] out_next;
  logic [1:0]        sel_idx;
  logic              sel_multi;
  phit_type_e        sel_type;
  state_e            state, state_next;
  logic [1:0]        src, src_next;
  logic [2:0]        err_new;
  logic              inc_pkt, inc_phit;

  assign phits[0] = i_phit0;
  assign phits[1] = i_phit1;
  assign phits[2] = i_phit2;
  assign phits[3] = i_phit3;

  // One-hot mux; an empty or multi-hot select yields an all-zero IDLE phit.
  always_comb begin
    sel_phit  = '0;
    sel_idx   = 2'd0;
    sel_multi = (i_select != 4'd0) && !$onehot(i_select);
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (i_select[i]) begin
        sel_phit = phits[i];
        sel_idx  = 2'(i);
      end
    end
    if (sel_multi) begin
      sel_phit = '0;
    end
  end

  assign sel_type = phit_type_e'(sel_phit[PHIT_W-1 -: 2]);

  route_shifter #(.PHIT_W(PHIT_W)) u_route_shifter (
    .phit_in  (sel_phit),
    .phit_out (shifted_phit)
  );

  // Framing FSM next-state, output phit selection and error/count events.
  always_comb begin
    state_next = state;
    src_next   = src;
    out_next   = sel_phit;
    err_new    = 3'b000;
    inc_pkt    = 1'b0;
    inc_phit   = 1'b0;

    err_new[0] = sel_multi;
    // A grant only makes sense on a head; anything else is flagged.
    if (i_shift && sel_type != PT_HEAD) begin
      err_new[2] = 1'b1;
    end

    if (sel_type == PT_HEAD) begin
      // A head starts a packet from either state (back-to-back allowed).
      state_next = S_PKT;
      src_next   = sel_idx;
      inc_pkt    = 1'b1;
      inc_phit   = 1'b1;
      if (i_shift) begin
        out_next = shifted_phit;
      end
    end else if (sel_type == PT_PAYLOAD) begin
      if (state == S_PKT && sel_idx == src) begin
        inc_phit = 1'b1;
      end else begin
        // Orphan payload (no open packet) or stray one from a different input.
        out_next   = '0;
        err_new[1] = 1'b1;
      end
    end else begin
      // IDLE or reserved closes any open packet.
      state_next = S_IDLE;
    end
  end

  // State, source index and the registered output link.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      src    <= 2'd0;
      o_phit <= '0;
    end else begin
      state  <= state_next;
      src    <= src_next;
      o_phit <= out_next;
    end
  end

  // Saturating statistics counters; a clear beats a coincident increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_cnt  <= '0;
      o_phit_cnt <= '0;
    end else if (i_clr_stats) begin
      o_pkt_cnt  <= '0;
      o_phit_cnt <= '0;
    end else begin
      if (inc_pkt && o_pkt_cnt != '1) begin
        o_pkt_cnt <= o_pkt_cnt + 1'b1;
      end
      if (inc_phit && o_phit_cnt != '1) begin
        o_phit_cnt <= o_phit_cnt + 1'b1;
      end
    end
  end

  // Sticky error flags; a new error survives a coincident clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 3'b000;
    end else begin
      o_err <= (i_clr_err ? 3'b000 : o_err) | err_new;
    end
  end

  assign o_busy  = (state == S_PKT);
  assign o_valid = (o_phit[PHIT_W-1 -: 2] == HEAD) || (o_phit[PHIT_W-1 -: 2] == PAYLOAD);

endmodule

// File: tb/tb_output_port_stage.sv
// Directed bench for output_port_stage (PHIT_W=8, CNT_W=4 so saturation is reachable).
module tb_output_port_stage;

  localparam int PHIT_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic [PHIT_W-1:0] phit0, phit1, phit2, phit3;
  logic [3:0]        select;
  logic              shift;
  logic              clr_stats;
  logic              clr_err;
  logic [PHIT_W-1:0] out_phit;
  logic              out_valid;
  logic              out_busy;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  phit_cnt;
  logic [2:0]        err;

  int n_checks = 0;
  int n_errors = 0;

  output_port_stage #(.PHIT_W(PHIT_W), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_phit0     (phit0),
    .i_phit1     (phit1),
    .i_phit2     (phit2),
    .i_phit3     (phit3),
    .i_select    (select),
    .i_shift     (shift),
    .i_clr_stats (clr_stats),
    .i_clr_err   (clr_err),
    .o_phit      (out_phit),
    .o_valid     (out_valid),
    .o_busy      (out_busy),
    .o_pkt_cnt   (pkt_cnt),
    .o_phit_cnt  (phit_cnt),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Wait one active edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one phit on a single input (select one-hot) for one cycle.
  task automatic put(input int port, input logic [7:0] ph, input logic sh);
    phit0 = '0; phit1 = '0; phit2 = '0; phit3 = '0;
    case (port)
      0: phit0 = ph;
      1: phit1 = ph;
      2: phit2 = ph;
      default: phit3 = ph;
    endcase
    select = 4'b0001 << port;
    shift  = sh;
    tick();
  endtask

  task automatic idle();
    phit0 = '0; phit1 = '0; phit2 = '0; phit3 = '0;
    select = 4'b0000;
    shift  = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; clr_stats = 1'b0; clr_err = 1'b0;
    phit0 = '0; phit1 = '0; phit2 = '0; phit3 = '0;
    select = 4'b0000; shift = 1'b0;
    #23;
    rst_n = 1'b1;

    // Idle after reset
    repeat (5) idle();
    check("rst_phit", 32'(out_phit), 32'h00);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(out_busy), 32'h0);
    check("rst_pkt", 32'(pkt_cnt), 32'h0);
    check("rst_phitc", 32'(phit_cnt), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // Head with route strip on input 2, two payloads, then idle
    put(2, 8'b11_10_01_11, 1'b1);
    check("p1_head", 32'(out_phit), 32'b11_01_11_00);
    check("p1_busy0", 32'(out_busy), 32'h1);
    check("p1_valid0", 32'(out_valid), 32'h1);
    put(2, 8'hA5, 1'b0);
    check("p1_pay0", 32'(out_phit), 32'hA5);
    check("p1_busy1", 32'(out_busy), 32'h1);
    put(2, 8'hA5, 1'b0);
    check("p1_pay1", 32'(out_phit), 32'hA5);
    check("p1_busy2", 32'(out_busy), 32'h1);
    idle();
    check("p1_idle", 32'(out_phit), 32'h00);
    check("p1_busy3", 32'(out_busy), 32'h0);
    check("p1_valid3", 32'(out_valid), 32'h0);
    check("p1_pkt", 32'(pkt_cnt), 32'h1);
    check("p1_phitc", 32'(phit_cnt), 32'h3);

    // Back-to-back heads on inputs 0 and 3
    clr_stats = 1'b1;
    idle();
    clr_stats = 1'b0;
    check("clr_pkt", 32'(pkt_cnt), 32'h0);
    check("clr_phitc", 32'(phit_cnt), 32'h0);
    put(0, 8'hC4, 1'b1);
    check("b2b_h0", 32'(out_phit), 32'hD0);
    put(0, 8'h81, 1'b0);
    check("b2b_p0", 32'(out_phit), 32'h81);
    put(3, 8'hFF, 1'b0);
    check("b2b_h3", 32'(out_phit), 32'hFF);
    check("b2b_busy", 32'(out_busy), 32'h1);
    put(3, 8'h9C, 1'b0);
    check("b2b_p3", 32'(out_phit), 32'h9C);
    check("b2b_busy2", 32'(out_busy), 32'h1);
    check("b2b_pkt", 32'(pkt_cnt), 32'h2);
    check("b2b_phitc", 32'(phit_cnt), 32'h4);
    check("b2b_err", 32'(err), 32'h0);
    idle();

    // Error flags
    put(0, 8'h80, 1'b0);
    check("orph_phit", 32'(out_phit), 32'h00);
    check("orph_err", 32'(err), 32'b010);
    check("orph_busy", 32'(out_busy), 32'h0);
    phit0 = 8'hC0; phit1 = 8'hC0; select = 4'b0011; shift = 1'b0;
    tick();
    check("multi_phit", 32'(out_phit), 32'h00);
    check("multi_err", 32'(err), 32'b011);
    put(1, 8'h8F, 1'b1);
    check("shpay_err", 32'(err), 32'b111);
    check("errs_phitc", 32'(phit_cnt), 32'h4);
    clr_err = 1'b1;
    phit0 = 8'hC0; phit1 = 8'hC0; select = 4'b0101; shift = 1'b0;
    tick();
    clr_err = 1'b0;
    check("clr_vs_new", 32'(err), 32'b001);

    // Counter saturation (CNT_W=4)
    clr_err = 1'b1; clr_stats = 1'b1;
    idle();
    clr_err = 1'b0; clr_stats = 1'b0;
    check("clr2_err", 32'(err), 32'h0);
    check("clr2_phitc", 32'(phit_cnt), 32'h0);
    put(1, 8'hC0, 1'b0);
    for (int i = 0; i < 14; i++) put(1, 8'h80 + 8'(i), 1'b0);
    check("sat_at15", 32'(phit_cnt), 32'hF);
    for (int i = 0; i < 5; i++) put(1, 8'h90 + 8'(i), 1'b0);
    check("sat_hold", 32'(phit_cnt), 32'hF);
    check("sat_pkt", 32'(pkt_cnt), 32'h1);
    check("sat_busy", 32'(out_busy), 32'h1);
    clr_stats = 1'b1;
    put(2, 8'hC0, 1'b0);
    clr_stats = 1'b0;
    check("clrhd_pkt", 32'(pkt_cnt), 32'h0);
    check("clrhd_phitc", 32'(phit_cnt), 32'h0);
    check("clrhd_phit", 32'(out_phit), 32'hC0);

    // Asynchronous reset mid-packet
    put(2, 8'h81, 1'b0);
    check("pre_rst_busy", 32'(out_busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_phit", 32'(out_phit), 32'h00);
    check("arst_busy", 32'(out_busy), 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    phit0 = '0; phit1 = '0; phit2 = '0; phit3 = '0; select = 4'b0000;
    #3;
    rst_n = 1'b1;
    put(2, 8'h82, 1'b0);
    check("post_rst_phit", 32'(out_phit), 32'h00);
    check("post_rst_err", 32'(err), 32'b010);
    check("post_rst_pkt", 32'(pkt_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
